assert_sched: RTL

Simulation-side assertion scheduler. It collects fire pulses from up to NUM_CHK checker instances and applies a per-checker enable mask. Failures are serialised through a round-robin report port, and a saturating failure count is kept. After a configurable failure threshold and a drain window, it sequences the end of simulation. It sits in the testbench next to the assertion checkers and replaces each checker's individual immediate halt with one ordered shutdown.

---
 rtl/assert_pkg.sv | 21 ++
 rtl/assert_sched_rr_arbiter.sv | 39 +++
 rtl/assert_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/assert_pkg.sv
// ============================================================================
// assert_pkg : shared FSM encoding and message colour codes for assert_sched
// Rev 1.0
// ============================================================================
`default_nettype none

package assert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } sched_state_t;

    localparam string c_esc_red   = "\033[31m";
    localparam string c_esc_reset = "\033[0m";

endpackage

`default_nettype wire

// File: rtl/assert_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin index picker, search begins at ptr and wraps
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 any_req
);

    localparam int IW = $clog2(N);
    localparam logic [IW:0] c_num = (IW+1)'(N);

    logic [IW:0] w_sum;
    logic [IW:0] w_idx;

    // Scan from farthest offset to nearest so the nearest requester wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr} + (IW+1)'(i);
            w_idx = (w_sum >= c_num) ? (w_sum - c_num) : w_sum;
            if (req[w_idx[IW-1:0]]) begin
                grant = w_idx[IW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/assert_sched.sv
// ============================================================================
// assert_sched : collects checker fires, serialises reports, sequences halt
// Optional: ASSERT_SCHED_FINISH_EN prints a red HALT message and calls $finish
// Rev 1.0
// ============================================================================
`default_nettype none

module assert_sched
    import assert_pkg::*;
#(
    parameter int NUM_CHK      = 8,
    parameter int CNT_W        = 8,
    parameter int MAX_FAILS    = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       arm,
    input  logic [NUM_CHK-1:0]         chk_fire,
    input  logic                       cfg_we,
    input  logic [NUM_CHK-1:0]         cfg_mask,
    output logic                       rpt_valid,
    output logic [$clog2(NUM_CHK)-1:0] rpt_id,
    input  logic                       rpt_ready,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       rpt_ovf,
    output logic [1:0]                 state,
    output logic                       halt_req
);

    localparam int ID_W = $clog2(NUM_CHK);
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_max_fails  = CNT_W'(MAX_FAILS);
    localparam logic [DR_W-1:0]  c_drain_load = DR_W'(DRAIN_CYCLES - 1);
    localparam logic [ID_W-1:0]  c_last_id    = ID_W'(NUM_CHK - 1);

    sched_state_t       r_state, w_state_next;
    logic [NUM_CHK-1:0] r_mask;
    logic [NUM_CHK-1:0] r_pend, w_pend_next;
    logic [ID_W-1:0]    r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [DR_W-1:0]    r_drain, w_drain_next;
    logic               r_ovf;

    logic [ID_W-1:0]    w_grant;
    logic               w_any;
    logic               w_valid;
    logic               w_accept;
    logic [NUM_CHK-1:0] w_fire;
    logic [NUM_CHK-1:0] w_acc_vec;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ID_W-1:0]    w_ptr_next;

    rr_arbiter #(.N(NUM_CHK)) u_arb (
        .req     (r_pend),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .any_req (w_any)
    );

    assign w_valid    = w_any && (r_state != ST_HALT);
    assign w_accept   = w_valid && rpt_ready;
    assign w_fire     = ((r_state == ST_ARMED) || (r_state == ST_DRAIN)) ? (chk_fire & r_mask) : '0;
    assign w_acc_vec  = w_accept ? (NUM_CHK'(1) << w_grant) : '0;
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + 1'b1);
    assign w_ptr_next = (w_grant == c_last_id) ? '0 : (w_grant + 1'b1);

    // A fire on the bit being accepted re-sets it: set has priority over clear.
    always_comb begin
        w_state_next = r_state;
        w_drain_next = r_drain;
        w_pend_next  = (r_pend & ~w_acc_vec) | w_fire;
        case (r_state)
            ST_IDLE: begin
                if (arm) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!arm) begin
                    w_state_next = ST_IDLE;
                    w_pend_next  = '0;
                end else if (w_accept && (w_cnt_inc >= c_max_fails)) begin
                    w_state_next = ST_DRAIN;
                    w_drain_next = c_drain_load;
                end
            end
            ST_DRAIN: begin
                if (r_drain == '0) w_state_next = ST_HALT;
                else               w_drain_next = r_drain - 1'b1;
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state <= ST_IDLE;
            r_mask  <= '1;
            r_pend  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_drain <= w_drain_next;
            if (cfg_we) r_mask <= cfg_mask;
            if (w_accept) begin
                r_ptr <= w_ptr_next;
                r_cnt <= w_cnt_inc;
            end
            if (|(w_fire & r_pend)) r_ovf <= 1'b1;
        end
    end

`ifdef ASSERT_SCHED_FINISH_EN
    logic [ID_W-1:0] r_last_id;

    always_ff @(posedge clk) begin
        if (!reset_)       r_last_id <= '0;
        else if (w_accept) r_last_id <= w_grant;
    end

    always_ff @(posedge clk) begin
        if (reset_ && (r_state != ST_HALT) && (w_state_next == ST_HALT)) begin
            $display("%s%m: state=HALT fail_cnt=%0d last rpt_id=%0d%s", c_esc_red,
                     w_accept ? w_cnt_inc : r_cnt, w_accept ? w_grant : r_last_id, c_esc_reset);
            $finish;
        end
    end
`endif

    assign rpt_valid = w_valid;
    assign rpt_id    = w_grant;
    assign fail_cnt  = r_cnt;
    assign rpt_ovf   = r_ovf;
    assign state     = r_state;
    assign halt_req  = (r_state == ST_HALT);

endmodule

`default_nettype wire
